// File: rtl/csr_file_if.sv
// Request/response bundle between the decode/EX stage (master) and the CSR file (slave).
// Carries the CSR access, the retire/trap/mret events and the trap-state outputs.
interface csr_if;
    logic [2:0]  csrsel;
    logic        csrread;
    logic        csrwrite;
    logic [11:0] csraddr;
    logic [31:0] rs1_data;
    logic [4:0]  zimm;
    logic        retire;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic        mret;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        mie_global;

    modport master (
        output csrsel, csrread, csrwrite, csraddr, rs1_data, zimm,
        output retire, trap_valid, trap_pc, trap_cause, mret,
        input  csr_rdata, csr_illegal, mtvec_out, mepc_out, mie_global
    );

    modport slave (
        input  csrsel, csrread, csrwrite, csraddr, rs1_data, zimm,
        input  retire, trap_valid, trap_pc, trap_cause, mret,
        output csr_rdata, csr_illegal, mtvec_out, mepc_out, mie_global
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational read of the pre-write value, single-edge commit,
// trap/mret state. Define CSR_COUNTERS_EN to build the 64-bit mcycle/minstret counters.
module csr_file #(
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_1100
) (
    input logic  clk,
    input logic  Rst,
    csr_if.slave bus
);
    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam logic [31:0] MIE_MASK     = 32'h0000_0888;
    localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;
    localparam logic [31:0] MTVEC_INIT   = MTVEC_RESET & ALIGN_MASK;

    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q,      mie_d;
    logic [31:0] mtvec_q,    mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q,     mepc_d;
    logic [31:0] mcause_q,   mcause_d;

    logic [31:0] cycle_lo, cycle_hi;
    logic [31:0] instret_lo, instret_hi;

    logic        access;
    logic        addr_mapped;
    logic [31:0] read_value;
    logic        illegal;
    logic [31:0] src;
    logic [31:0] wdata;
    logic        wr_en;

    // ------------------------------------------------------------------
    // Read path and legality
    // ------------------------------------------------------------------
    assign access = bus.csrread | bus.csrwrite;

    always_comb begin
        read_value  = '0;
        addr_mapped = 1'b1;
        case (bus.csraddr)
            ADDR_MSTATUS:   read_value = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
            ADDR_MISA:      read_value = MISA_VALUE;
            ADDR_MIE:       read_value = mie_q;
            ADDR_MTVEC:     read_value = mtvec_q;
            ADDR_MSCRATCH:  read_value = mscratch_q;
            ADDR_MEPC:      read_value = mepc_q;
            ADDR_MCAUSE:    read_value = mcause_q;
            ADDR_MCYCLE:    read_value = cycle_lo;
            ADDR_MCYCLEH:   read_value = cycle_hi;
            ADDR_MINSTRET:  read_value = instret_lo;
            ADDR_MINSTRETH: read_value = instret_hi;
            ADDR_MHARTID:   read_value = HART_ID;
            default:        addr_mapped = 1'b0;
        endcase
    end

    assign illegal = access & (~addr_mapped
                               | (bus.csrwrite & (bus.csraddr[11:10] == 2'b11))
                               | (bus.csrsel[1:0] == 2'b00));

    assign bus.csr_rdata   = access ? read_value : 32'h0;
    assign bus.csr_illegal = illegal;

    // ------------------------------------------------------------------
    // Write data: RW / RS / RC on register or zero-extended immediate
    // ------------------------------------------------------------------
    assign src = bus.csrsel[2] ? {27'b0, bus.zimm} : bus.rs1_data;

    always_comb begin
        wdata = read_value;
        case (bus.csrsel[1:0])
            2'b01:   wdata = src;
            2'b10:   wdata = read_value | src;
            2'b11:   wdata = read_value & ~src;
            default: wdata = read_value;
        endcase
    end

    // A trap in the same cycle swallows the CSR write entirely.
    assign wr_en = bus.csrwrite & ~illegal & ~bus.trap_valid;

    // ------------------------------------------------------------------
    // Next-state for the non-counter CSRs
    // ------------------------------------------------------------------
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;

        if (bus.trap_valid) begin
            mepc_d         = bus.trap_pc & ALIGN_MASK;
            mcause_d       = bus.trap_cause;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (bus.mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end

        if (wr_en) begin
            case (bus.csraddr)
                ADDR_MSTATUS: begin
                    // mret owns mstatus in the cycle it executes.
                    if (!bus.mret) begin
                        mstatus_mie_d  = wdata[3];
                        mstatus_mpie_d = wdata[7];
                    end
                end
                ADDR_MIE:      mie_d      = wdata & MIE_MASK;
                ADDR_MTVEC:    mtvec_d    = wdata & ALIGN_MASK;
                ADDR_MSCRATCH: mscratch_d = wdata;
                ADDR_MEPC:     mepc_d     = wdata & ALIGN_MASK;
                ADDR_MCAUSE:   mcause_d   = wdata;
                default:       ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= MTVEC_INIT;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
        end
    end

    // ------------------------------------------------------------------
    // 64-bit counters
    // ------------------------------------------------------------------
`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q,   mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    // A written half takes the write data; writing low suppresses the carry into high,
    // writing high drops any carry out of the still-incrementing low half.
    function automatic logic [63:0] counter_next(
        input logic [63:0] cur,
        input logic        inc,
        input logic        wr_lo,
        input logic        wr_hi,
        input logic [31:0] wd
    );
        logic [32:0] lo_sum;
        logic [31:0] hi_sum;
        lo_sum = {1'b0, cur[31:0]} + {32'b0, inc};
        hi_sum = cur[63:32] + {31'b0, lo_sum[32]};
        if (wr_lo) begin
            return {cur[63:32], wd};
        end
        if (wr_hi) begin
            return {wd, lo_sum[31:0]};
        end
        return {hi_sum, lo_sum[31:0]};
    endfunction

    always_comb begin
        mcycle_d   = counter_next(mcycle_q, 1'b1,
                                  wr_en && (bus.csraddr == ADDR_MCYCLE),
                                  wr_en && (bus.csraddr == ADDR_MCYCLEH), wdata);
        minstret_d = counter_next(minstret_q, bus.retire,
                                  wr_en && (bus.csraddr == ADDR_MINSTRET),
                                  wr_en && (bus.csraddr == ADDR_MINSTRETH), wdata);
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign cycle_lo   = mcycle_q[31:0];
    assign cycle_hi   = mcycle_q[63:32];
    assign instret_lo = minstret_q[31:0];
    assign instret_hi = minstret_q[63:32];
`else
    logic unused_retire;

    assign unused_retire = bus.retire;
    assign cycle_lo      = '0;
    assign cycle_hi      = '0;
    assign instret_lo    = '0;
    assign instret_hi    = '0;
`endif

    assign bus.mtvec_out  = mtvec_q;
    assign bus.mepc_out   = mepc_q;
    assign bus.mie_global = mstatus_mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed scenarios followed by random CSR traffic, all compared
// against an architectural model of the machine-mode CSRs kept in this module.
module tb_csr_file;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    csr_if u_if ();

    csr_file #(
        .HART_ID    (32'h0000_0005),
        .MTVEC_RESET(32'h8000_0003),
        .MISA_VALUE (32'h4000_1100)
    ) dut (
        .clk(clk),
        .Rst(rst),
        .bus(u_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Architectural model state
    bit          m_mie, m_mpie;
    logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_cycle, m_instret;

    logic [31:0] last_rdata;
    logic        last_illegal;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_mie      = 1'b0;
        m_mpie     = 1'b0;
        m_mie_reg  = 32'h0;
        m_mtvec    = 32'h8000_0000;
        m_mscratch = 32'h0;
        m_mepc     = 32'h0;
        m_mcause   = 32'h0;
        m_cycle    = 64'h0;
        m_instret  = 64'h0;
    endfunction

    function automatic bit model_mapped(input logic [11:0] a);
        return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14};
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0);
            12'h301: return 32'h4000_1100;
            12'h304: return m_mie_reg;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
`ifdef CSR_COUNTERS_EN
            12'hB00: return m_cycle[31:0];
            12'hB80: return m_cycle[63:32];
            12'hB02: return m_instret[31:0];
            12'hB82: return m_instret[63:32];
`endif
            12'hF14: return 32'h0000_0005;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_illegal(input logic [2:0] sel, input bit rd, input bit wr,
                                         input logic [11:0] a);
        if (!(rd || wr)) return 1'b0;
        return !model_mapped(a) || (wr && a >= 12'hC00) || (sel % 4 == 0);
    endfunction

    // Advance the model across one rising edge, given the inputs held during that cycle.
    function automatic void model_step(input logic [2:0] sel, input bit rd, input bit wr,
                                       input logic [11:0] a, input logic [31:0] rs1,
                                       input logic [4:0] zimm, input bit ret, input bit trap,
                                       input logic [31:0] tpc, input logic [31:0] tcause,
                                       input bit mret_i);
        logic [31:0] src, old, nv;
        logic [63:0] cyc_n, ins_n;
        bit          do_write;
        src      = sel[2] ? 32'(zimm) : rs1;
        old      = model_read(a);
        nv       = old;
        if (sel % 4 == 1) nv = src;
        if (sel % 4 == 2) nv = old | src;
        if (sel % 4 == 3) nv = old & ~src;
        do_write = wr && !model_illegal(sel, rd, wr, a) && !trap;
        cyc_n    = m_cycle + 64'd1;
        ins_n    = m_instret + (ret ? 64'd1 : 64'd0);
        if (trap) begin
            m_mepc   = tpc & 32'hFFFF_FFFC;
            m_mcause = tcause;
            m_mpie   = m_mie;
            m_mie    = 1'b0;
        end else if (mret_i) begin
            m_mie  = m_mpie;
            m_mpie = 1'b1;
        end
        if (do_write) begin
            case (a)
                12'h300: if (!mret_i) begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h304: m_mie_reg  = nv & 32'h888;
                12'h305: m_mtvec    = nv & 32'hFFFF_FFFC;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc     = nv & 32'hFFFF_FFFC;
                12'h342: m_mcause   = nv;
`ifdef CSR_COUNTERS_EN
                12'hB00: cyc_n = {m_cycle[63:32], nv};
                12'hB80: cyc_n = {nv, cyc_n[31:0]};
                12'hB02: ins_n = {m_instret[63:32], nv};
                12'hB82: ins_n = {nv, ins_n[31:0]};
`endif
                default: ;
            endcase
        end
        m_cycle   = cyc_n;
        m_instret = ins_n;
    endfunction

    // One clock of stimulus; called at a negedge, returns at the next negedge.
    task automatic cycle_op(input string tag, input logic [2:0] sel, input bit rd, input bit wr,
                            input logic [11:0] a, input logic [31:0] rs1, input logic [4:0] zimm,
                            input bit ret, input bit trap, input logic [31:0] tpc,
                            input logic [31:0] tcause, input bit mret_i);
        logic [31:0] exp_rdata;
        u_if.csrsel     = sel;
        u_if.csrread    = rd;
        u_if.csrwrite   = wr;
        u_if.csraddr    = a;
        u_if.rs1_data   = rs1;
        u_if.zimm       = zimm;
        u_if.retire     = ret;
        u_if.trap_valid = trap;
        u_if.trap_pc    = tpc;
        u_if.trap_cause = tcause;
        u_if.mret       = mret_i;
        #1;
        exp_rdata    = (rd || wr) ? model_read(a) : 32'h0;
        last_rdata   = u_if.csr_rdata;
        last_illegal = u_if.csr_illegal;
        $display("txn %s sel=%0d rd=%0d wr=%0d addr=%03h src=%08h trap=%0d mret=%0d rdata=%08h ill=%0d",
                 tag, sel, rd, wr, a, sel[2] ? 32'(zimm) : rs1, trap, mret_i, last_rdata, last_illegal);
        check({tag, "_rdata"}, last_rdata, exp_rdata);
        check({tag, "_illegal"}, 32'(last_illegal), 32'(model_illegal(sel, rd, wr, a)));
        @(posedge clk);
        model_step(sel, rd, wr, a, rs1, zimm, ret, trap, tpc, tcause, mret_i);
        @(negedge clk);
        check({tag, "_mtvec"}, u_if.mtvec_out, m_mtvec);
        check({tag, "_mepc"}, u_if.mepc_out, m_mepc);
        check({tag, "_mie"}, 32'(u_if.mie_global), 32'(m_mie));
    endtask

    task automatic rd_csr(input string tag, input logic [11:0] a);
        cycle_op(tag, 3'b010, 1'b1, 1'b0, a, 32'h0, 5'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic wr_csr(input string tag, input logic [2:0] sel, input logic [11:0] a,
                          input logic [31:0] rs1, input logic [4:0] zimm);
        cycle_op(tag, sel, 1'b1, 1'b1, a, rs1, zimm, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic idle(input string tag, input bit ret);
        cycle_op(tag, 3'b000, 1'b0, 1'b0, 12'h000, 32'h0, 5'h0, ret, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    logic [11:0] addr_pool [15] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                    12'h342, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14,
                                    12'h7C0, 12'h000, 12'h344};

    initial begin
        logic [2:0]  r_sel;
        bit          r_rd, r_wr, r_trap, r_mret, r_ret;
        logic [11:0] r_addr;
        logic [31:0] r_rs1;

        rst             = 1'b1;
        u_if.csrsel     = 3'b0;
        u_if.csrread    = 1'b0;
        u_if.csrwrite   = 1'b0;
        u_if.csraddr    = 12'h0;
        u_if.rs1_data   = 32'h0;
        u_if.zimm       = 5'h0;
        u_if.retire     = 1'b0;
        u_if.trap_valid = 1'b0;
        u_if.trap_pc    = 32'h0;
        u_if.trap_cause = 32'h0;
        u_if.mret       = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_mtvec", u_if.mtvec_out, 32'h8000_0000);
        check("reset_mepc", u_if.mepc_out, 32'h0);
        check("reset_mie", 32'(u_if.mie_global), 32'h0);
        check("reset_rdata_idle", u_if.csr_rdata, 32'h0);
        check("reset_illegal_idle", 32'(u_if.csr_illegal), 32'h0);
        rst = 1'b0;

        rd_csr("rd_mtvec", 12'h305);
        check("plan_mtvec", last_rdata, 32'h8000_0000);
        rd_csr("rd_hartid", 12'hF14);
        check("plan_hartid", last_rdata, 32'h0000_0005);
        rd_csr("rd_misa", 12'h301);
        check("plan_misa", last_rdata, 32'h4000_1100);

        wr_csr("rw_mscratch", 3'b001, 12'h340, 32'hDEAD_BEEF, 5'h0);
        check("plan_rw_old", last_rdata, 32'h0);
        wr_csr("rw_mscratch_f", 3'b001, 12'h340, 32'h0000_000F, 5'h0);
        check("plan_rw_prev", last_rdata, 32'hDEAD_BEEF);
        wr_csr("rs_mscratch", 3'b010, 12'h340, 32'h0000_00F0, 5'h0);
        check("plan_rs_old", last_rdata, 32'h0000_000F);
        rd_csr("rd_mscratch", 12'h340);
        check("plan_rs_new", last_rdata, 32'h0000_00FF);
        wr_csr("rci_mscratch", 3'b111, 12'h340, 32'hFFFF_FFFF, 5'h0F);
        rd_csr("rd_mscratch2", 12'h340);
        check("plan_rci_new", last_rdata, 32'h0000_00F0);

        wr_csr("wr_hartid", 3'b001, 12'hF14, 32'h1234_5678, 5'h0);
        check("plan_hartid_wr_illegal", 32'(last_illegal), 32'h1);
        rd_csr("rd_hartid2", 12'hF14);
        check("plan_hartid_kept", last_rdata, 32'h0000_0005);
        rd_csr("rd_unmapped", 12'h7C0);
        check("plan_unmapped_illegal", 32'(last_illegal), 32'h1);

        wr_csr("rsi_mstatus", 3'b110, 12'h300, 32'h0, 5'h08);
        check("plan_mie_set", 32'(u_if.mie_global), 32'h1);
        cycle_op("trap_w_write", 3'b001, 1'b1, 1'b1, 12'h340, 32'h1234_5678, 5'h0,
                 1'b0, 1'b1, 32'h0000_0106, 32'h0000_000B, 1'b0);
        check("plan_trap_mepc", u_if.mepc_out, 32'h0000_0104);
        check("plan_trap_mie", 32'(u_if.mie_global), 32'h0);
        rd_csr("rd_mcause", 12'h342);
        check("plan_trap_mcause", last_rdata, 32'h0000_000B);
        rd_csr("rd_mstatus", 12'h300);
        check("plan_trap_mstatus", last_rdata, 32'h0000_1880);
        rd_csr("rd_mscratch3", 12'h340);
        check("plan_trap_mscratch", last_rdata, 32'h0000_00F0);
        cycle_op("mret_w_mstatus", 3'b001, 1'b0, 1'b1, 12'h300, 32'h0, 5'h0,
                 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        rd_csr("rd_mstatus2", 12'h300);
        check("plan_mret_mstatus", last_rdata, 32'h0000_1888);

        wr_csr("wr_mcycle", 3'b001, 12'hB00, 32'hFFFF_FFFE, 5'h0);
        wr_csr("wr_mcycleh", 3'b001, 12'hB80, 32'h0, 5'h0);
        idle("ctr_idle", 1'b0);
        rd_csr("rd_mcycle", 12'hB00);
        rd_csr("rd_mcycleh", 12'hB80);
        rd_csr("rd_minstret_a", 12'hB02);
        for (int i = 0; i < 5; i++) idle("retire", 1'b1);
        rd_csr("rd_minstret_b", 12'hB02);

        // Reset asserted while a CSRRW to mscratch is on the bus
        u_if.csrsel   = 3'b001;
        u_if.csrread  = 1'b1;
        u_if.csrwrite = 1'b1;
        u_if.csraddr  = 12'h340;
        u_if.rs1_data = 32'hAAAA_5555;
        #1 rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_mtvec", u_if.mtvec_out, 32'h8000_0000);
        check("rst_mid_mie", 32'(u_if.mie_global), 32'h0);
        rd_csr("rd_mscratch_rst", 12'h340);
        check("plan_rst_mscratch", last_rdata, 32'h0);
        rd_csr("rd_mstatus_rst", 12'h300);
        check("plan_rst_mstatus", last_rdata, 32'h0000_1800);
        rd_csr("rd_mcycle_rst", 12'hB00);
        check("plan_ctr_legal", 32'(last_illegal), 32'h0);

        for (int n = 0; n < 400; n++) begin
            r_addr = addr_pool[$urandom_range(0, 14)];
            r_sel  = 3'($urandom_range(0, 7));
            r_rd   = ($urandom_range(0, 3) != 0);
            r_wr   = ($urandom_range(0, 1) == 1);
            r_trap = ($urandom_range(0, 15) == 0);
            r_mret = ($urandom_range(0, 9) == 0);
            r_ret  = ($urandom_range(0, 1) == 1);
            r_rs1  = $urandom();
            if (r_mret && r_wr && r_addr != 12'h300) r_wr = 1'b0;
            cycle_op("rand", r_sel, r_rd, r_wr, r_addr, r_rs1, 5'($urandom_range(0, 31)),
                     r_ret, r_trap, $urandom(), $urandom(), r_mret);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
